// File: rtl/apb_ucpd_tx_fsm_pkg.sv
// Shared encodings for the UCPD transmit sequencer: state codes, phase lengths, tx_mode codes.
package apb_ucpd_tx_fsm_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SOP  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CRC  = 3'd4;
    localparam logic [2:0] ST_EOP  = 3'd5;
    localparam logic [2:0] ST_WAIT = 3'd6;

    localparam int unsigned PRE_BITS_DFLT = 128;
    localparam int unsigned SOP_BITS_DFLT = 20;
    localparam int unsigned CRC_BITS_DFLT = 40;
    localparam int unsigned EOP_BITS_DFLT = 5;
    localparam int unsigned IFG_BITS_DFLT = 25;
    // One payload byte is 10 encoded bits (two 4b5b symbols).
    localparam int unsigned BYTE_BITS     = 10;
    localparam int unsigned BITCNT_W      = 7;

    localparam logic [1:0] TXMODE_NORMAL = 2'b00;
    localparam logic [1:0] TXMODE_CRST   = 2'b01;

endpackage

// File: rtl/apb_ucpd_tx_bitcnt.sv
// Bit-time counter for the transmit sequencer: clears on request, counts bit_clk_red pulses,
// saturates at the terminal value and flags the terminal bit.
module apb_ucpd_tx_bitcnt
    import apb_ucpd_tx_fsm_pkg::*;
(
    input  logic                ic_clk,
    input  logic                ic_rst_n,
    input  logic                clr,
    input  logic                bit_clk_red,
    input  logic [BITCNT_W-1:0] term,
    output logic                term_hit
);

    logic [BITCNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (bit_clk_red && (cnt_q != term)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_hit = bit_clk_red && (cnt_q == term);

endmodule

// File: rtl/apb_ucpd_tx_fsm.sv
// UCPD transmit sequencer: walks preamble, SOP, payload, CRC, EOP and inter-frame gap,
// and handles hard/cable reset frames, discards and hard-reset abort.
module apb_ucpd_tx_fsm
    import apb_ucpd_tx_fsm_pkg::*;
#(
    parameter int unsigned PRE_BITS = PRE_BITS_DFLT,
    parameter int unsigned SOP_BITS = SOP_BITS_DFLT,
    parameter int unsigned CRC_BITS = CRC_BITS_DFLT,
    parameter int unsigned EOP_BITS = EOP_BITS_DFLT,
    parameter int unsigned IFG_BITS = IFG_BITS_DFLT,
    parameter int unsigned PAYSZ_W  = 10
) (
    input  logic               ic_clk,
    input  logic               ic_rst_n,
    input  logic               bit_clk_red,
    input  logic               transmit_en,
    input  logic               tx_hrst,
    input  logic [1:0]         tx_mode,
    input  logic [PAYSZ_W-1:0] tx_paysz,
    input  logic               rx_busy,
    input  logic               hrst_tx_en,
    output logic               pre_en,
    output logic               sop_en,
    output logic               data_en,
    output logic               crc_en,
    output logic               eop_en,
    output logic               txfifo_ld_en,
    output logic               txdr_req,
    output logic               tx_sop_cmplt,
    output logic               tx_data_cmplt,
    output logic               tx_crc_cmplt,
    output logic               tx_eop_cmplt,
    output logic               tx_wait_cmplt,
    output logic               tx_msg_disc,
    output logic               tx_hrst_disc,
    output logic               tx_busy
);

    localparam logic [BITCNT_W-1:0] PRE_TERM  = BITCNT_W'(PRE_BITS - 1);
    localparam logic [BITCNT_W-1:0] SOP_TERM  = BITCNT_W'(SOP_BITS - 1);
    localparam logic [BITCNT_W-1:0] BYTE_TERM = BITCNT_W'(BYTE_BITS - 1);
    localparam logic [BITCNT_W-1:0] CRC_TERM  = BITCNT_W'(CRC_BITS - 1);
    localparam logic [BITCNT_W-1:0] EOP_TERM  = BITCNT_W'(EOP_BITS - 1);
    localparam logic [BITCNT_W-1:0] IFG_TERM  = BITCNT_W'(IFG_BITS - 1);

    logic [2:0]         state_q, state_d;
    logic               hrst_frm_q, hrst_frm_d;
    logic               crst_frm_q, crst_frm_d;
    logic               hrst_abort_q, hrst_abort_d;
    logic               hrst_pend_q, hrst_pend_d;
    logic [PAYSZ_W-1:0] paysz_q, paysz_d;
    logic [PAYSZ_W-1:0] byte_cnt_q, byte_cnt_d;
    logic               txdr_req_q, txdr_req_d;
    logic               tx_hrst_q, transmit_en_q;

    logic               hrst_rise, tx_rise;
    logic               pre_restart, byte_adv, last_byte;
    logic               bit_clr, term_hit;
    logic [BITCNT_W-1:0] term;
    logic [PAYSZ_W:0]   paysz_ext, byte_cnt_ext, ld_idx;

    assign hrst_rise    = tx_hrst & ~tx_hrst_q;
    assign tx_rise      = transmit_en & ~transmit_en_q;
    assign paysz_ext    = {1'b0, paysz_q};
    assign byte_cnt_ext = {1'b0, byte_cnt_q};
    assign last_byte    = (byte_cnt_ext + 1'b1) >= paysz_ext;

    always_comb begin
        case (state_q)
            ST_PRE:  term = PRE_TERM;
            ST_SOP:  term = SOP_TERM;
            ST_DATA: term = BYTE_TERM;
            ST_CRC:  term = CRC_TERM;
            ST_EOP:  term = EOP_TERM;
            ST_WAIT: term = IFG_TERM;
            default: term = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        hrst_frm_d    = hrst_frm_q;
        crst_frm_d    = crst_frm_q;
        hrst_abort_d  = hrst_abort_q;
        hrst_pend_d   = hrst_pend_q;
        paysz_d       = paysz_q;
        byte_cnt_d    = byte_cnt_q;
        pre_restart   = 1'b0;
        byte_adv      = 1'b0;
        txfifo_ld_en  = 1'b0;
        tx_sop_cmplt  = 1'b0;
        tx_data_cmplt = 1'b0;
        tx_crc_cmplt  = 1'b0;
        tx_eop_cmplt  = 1'b0;
        tx_wait_cmplt = 1'b0;
        tx_msg_disc   = 1'b0;
        tx_hrst_disc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A hard reset held pending from EOP/WAIT acts like a fresh edge here.
                if (hrst_rise || hrst_pend_q) begin
                    hrst_pend_d = 1'b0;
                    if (rx_busy) begin
                        tx_hrst_disc = 1'b1;
                    end else begin
                        state_d    = ST_PRE;
                        hrst_frm_d = 1'b1;
                        crst_frm_d = 1'b0;
                    end
                end else if (tx_rise) begin
                    if (rx_busy) begin
                        tx_msg_disc = 1'b1;
                    end else begin
                        state_d    = ST_PRE;
                        hrst_frm_d = 1'b0;
                        crst_frm_d = (tx_mode == TXMODE_CRST);
                    end
                end
            end
            ST_PRE: begin
                if (hrst_rise) begin
                    hrst_frm_d  = 1'b1;
                    crst_frm_d  = 1'b0;
                    pre_restart = 1'b1;
                end else if (term_hit) begin
                    state_d = ST_SOP;
                end
            end
            ST_SOP: begin
                if (hrst_rise) begin
                    hrst_abort_d = 1'b1;
                    state_d      = ST_EOP;
                end else if (term_hit) begin
                    tx_sop_cmplt = 1'b1;
                    if (hrst_frm_q || crst_frm_q) begin
                        state_d = ST_WAIT;
                    end else if (paysz_q == '0) begin
                        tx_data_cmplt = 1'b1;
                        state_d       = ST_CRC;
                    end else begin
                        state_d      = ST_DATA;
                        txfifo_ld_en = 1'b1;
                        byte_cnt_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (hrst_rise) begin
                    hrst_abort_d = 1'b1;
                    state_d      = ST_EOP;
                end else if (term_hit) begin
                    if (last_byte) begin
                        tx_data_cmplt = 1'b1;
                        state_d       = ST_CRC;
                    end else begin
                        txfifo_ld_en = 1'b1;
                        byte_adv     = 1'b1;
                        byte_cnt_d   = byte_cnt_q + 1'b1;
                    end
                end
            end
            ST_CRC: begin
                if (hrst_rise) begin
                    hrst_abort_d = 1'b1;
                    state_d      = ST_EOP;
                end else if (term_hit) begin
                    tx_crc_cmplt = 1'b1;
                    state_d      = ST_EOP;
                end
            end
            ST_EOP: begin
                if (hrst_rise) begin
                    hrst_pend_d = 1'b1;
                end
                if (term_hit) begin
                    tx_eop_cmplt = 1'b1;
                    if (hrst_abort_q || hrst_tx_en) begin
                        state_d      = ST_PRE;
                        hrst_frm_d   = 1'b1;
                        crst_frm_d   = 1'b0;
                        hrst_abort_d = 1'b0;
                        hrst_pend_d  = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (hrst_rise) begin
                    hrst_pend_d = 1'b1;
                end
                if (term_hit) begin
                    tx_wait_cmplt = 1'b1;
                    state_d       = ST_IDLE;
                    hrst_frm_d    = 1'b0;
                    crst_frm_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_PRE) && ((state_q != ST_PRE) || pre_restart)) begin
            paysz_d = tx_paysz;
        end
    end

    // Request the next TXDR write only if another byte remains after the one just loaded.
    assign ld_idx     = byte_adv ? (byte_cnt_ext + 1'b1) : '0;
    assign txdr_req_d = txfifo_ld_en && ((ld_idx + 1'b1) < paysz_ext);

    assign bit_clr = (state_d != state_q) || pre_restart || byte_adv || (state_q == ST_IDLE);

    apb_ucpd_tx_bitcnt u_bitcnt (
        .ic_clk      (ic_clk),
        .ic_rst_n    (ic_rst_n),
        .clr         (bit_clr),
        .bit_clk_red (bit_clk_red),
        .term        (term),
        .term_hit    (term_hit)
    );

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state_q       <= ST_IDLE;
            hrst_frm_q    <= 1'b0;
            crst_frm_q    <= 1'b0;
            hrst_abort_q  <= 1'b0;
            hrst_pend_q   <= 1'b0;
            paysz_q       <= '0;
            byte_cnt_q    <= '0;
            txdr_req_q    <= 1'b0;
            tx_hrst_q     <= 1'b0;
            transmit_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hrst_frm_q    <= hrst_frm_d;
            crst_frm_q    <= crst_frm_d;
            hrst_abort_q  <= hrst_abort_d;
            hrst_pend_q   <= hrst_pend_d;
            paysz_q       <= paysz_d;
            byte_cnt_q    <= byte_cnt_d;
            txdr_req_q    <= txdr_req_d;
            tx_hrst_q     <= tx_hrst;
            transmit_en_q <= transmit_en;
        end
    end

    assign pre_en   = (state_q == ST_PRE);
    assign sop_en   = (state_q == ST_SOP);
    assign data_en  = (state_q == ST_DATA);
    assign crc_en   = (state_q == ST_CRC);
    assign eop_en   = (state_q == ST_EOP);
    assign txdr_req = txdr_req_q;
    assign tx_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apb_ucpd_tx_fsm.sv
// Scoreboard bench for apb_ucpd_tx_fsm: expected phase lengths and pulses are queued by the
// stimulus and matched by an independent output monitor.
module tb_apb_ucpd_tx_fsm;

    localparam int K_PRE = 0, K_SOP = 1, K_DATA = 2, K_CRC = 3, K_EOP = 4, K_WAIT = 5, K_BAD = 6;
    localparam int K_LD = 10, K_TXDR = 11, K_SOPC = 12, K_DATAC = 13, K_CRCC = 14;
    localparam int K_EOPC = 15, K_WAITC = 16, K_MDISC = 17, K_HDISC = 18;
    localparam int BUDGET = 4000;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       ic_clk = 1'b0;
    logic       ic_rst_n;
    logic       bit_clk_red;
    logic       transmit_en, tx_hrst, rx_busy, hrst_tx_en;
    logic [1:0] tx_mode;
    logic [9:0] tx_paysz;
    logic pre_en, sop_en, data_en, crc_en, eop_en, txfifo_ld_en, txdr_req;
    logic tx_sop_cmplt, tx_data_cmplt, tx_crc_cmplt, tx_eop_cmplt, tx_wait_cmplt;
    logic tx_msg_disc, tx_hrst_disc, tx_busy;
    logic [14:0] outs;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;

    apb_ucpd_tx_fsm dut (
        .ic_clk        (ic_clk),
        .ic_rst_n      (ic_rst_n),
        .bit_clk_red   (bit_clk_red),
        .transmit_en   (transmit_en),
        .tx_hrst       (tx_hrst),
        .tx_mode       (tx_mode),
        .tx_paysz      (tx_paysz),
        .rx_busy       (rx_busy),
        .hrst_tx_en    (hrst_tx_en),
        .pre_en        (pre_en),
        .sop_en        (sop_en),
        .data_en       (data_en),
        .crc_en        (crc_en),
        .eop_en        (eop_en),
        .txfifo_ld_en  (txfifo_ld_en),
        .txdr_req      (txdr_req),
        .tx_sop_cmplt  (tx_sop_cmplt),
        .tx_data_cmplt (tx_data_cmplt),
        .tx_crc_cmplt  (tx_crc_cmplt),
        .tx_eop_cmplt  (tx_eop_cmplt),
        .tx_wait_cmplt (tx_wait_cmplt),
        .tx_msg_disc   (tx_msg_disc),
        .tx_hrst_disc  (tx_hrst_disc),
        .tx_busy       (tx_busy)
    );

    assign outs = {pre_en, sop_en, data_en, crc_en, eop_en, txfifo_ld_en, txdr_req,
                   tx_sop_cmplt, tx_data_cmplt, tx_crc_cmplt, tx_eop_cmplt, tx_wait_cmplt,
                   tx_msg_disc, tx_hrst_disc, tx_busy};

    always #5 ic_clk = ~ic_clk;

    // One bit time every 4 clocks.
    initial begin
        bit_clk_red = 1'b0;
        forever begin
            @(posedge ic_clk);
            #1;
            cyc++;
            bit_clk_red = (cyc % 4 == 0);
        end
    end

    function automatic string kname(int k);
        case (k)
            K_PRE:   return "PRE";
            K_SOP:   return "SOP";
            K_DATA:  return "DATA";
            K_CRC:   return "CRC";
            K_EOP:   return "EOP";
            K_WAIT:  return "WAIT";
            K_BAD:   return "MULTI_EN";
            K_LD:    return "txfifo_ld_en";
            K_TXDR:  return "txdr_req";
            K_SOPC:  return "tx_sop_cmplt";
            K_DATAC: return "tx_data_cmplt";
            K_CRCC:  return "tx_crc_cmplt";
            K_EOPC:  return "tx_eop_cmplt";
            K_WAITC: return "tx_wait_cmplt";
            K_MDISC: return "tx_msg_disc";
            K_HDISC: return "tx_hrst_disc";
            default: return "none";
        endcase
    endfunction

    function automatic int phase_now();
        int n;
        n = int'(pre_en) + int'(sop_en) + int'(data_en) + int'(crc_en) + int'(eop_en);
        if (n > 1) return K_BAD;
        if (pre_en) return K_PRE;
        if (sop_en) return K_SOP;
        if (data_en) return K_DATA;
        if (crc_en) return K_CRC;
        if (eop_en) return K_EOP;
        if (tx_busy) return K_WAIT;
        return -1;
    endfunction

    task automatic push_ev(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input int v);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: got %s/%0d expected nothing", kname(k), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                bad++;
                $display("FAIL scoreboard: got %s/%0d expected %s/%0d",
                         kname(k), v, kname(e.kind), e.val);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge ic_clk);
        while ((tx_busy || exp_q.size() != 0) && n < BUDGET) begin
            @(negedge ic_clk);
            n++;
        end
        total++;
        if (n >= BUDGET) begin
            bad++;
            $display("FAIL %s timeout: busy=%0d pending=%0d expected busy=0 pending=0",
                     name, tx_busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic push_rst_frame();
        push_ev(K_PRE, 128);
        push_ev(K_SOPC, 0);
        push_ev(K_SOP, 20);
        push_ev(K_WAITC, 0);
        push_ev(K_WAIT, 25);
    endtask

    task automatic push_normal2();
        push_ev(K_PRE, 128);
        push_ev(K_LD, 0);
        push_ev(K_SOPC, 0);
        push_ev(K_SOP, 20);
        push_ev(K_TXDR, 0);
        push_ev(K_LD, 0);
        push_ev(K_DATAC, 0);
        push_ev(K_DATA, 20);
        push_ev(K_CRCC, 0);
        push_ev(K_CRC, 40);
        push_ev(K_EOPC, 0);
        push_ev(K_EOP, 5);
        push_ev(K_WAITC, 0);
        push_ev(K_WAIT, 25);
    endtask

    // Monitor: reports each finished phase with its bit count, then any pulses of that cycle.
    initial begin : monitor
        int cur;
        int cnt;
        int ph;
        cur = -1;
        cnt = 0;
        forever begin
            @(negedge ic_clk);
            if (!ic_rst_n) begin
                cur = -1;
                cnt = 0;
            end else begin
                ph = phase_now();
                if (ph != cur) begin
                    if (cur != -1) observe(cur, cnt);
                    cur = ph;
                    cnt = 0;
                end
                if (bit_clk_red && ph != -1) cnt++;
                if (txfifo_ld_en)  observe(K_LD, 0);
                if (txdr_req)      observe(K_TXDR, 0);
                if (tx_sop_cmplt)  observe(K_SOPC, 0);
                if (tx_data_cmplt) observe(K_DATAC, 0);
                if (tx_crc_cmplt)  observe(K_CRCC, 0);
                if (tx_eop_cmplt)  observe(K_EOPC, 0);
                if (tx_wait_cmplt) observe(K_WAITC, 0);
                if (tx_msg_disc)   observe(K_MDISC, 0);
                if (tx_hrst_disc)  observe(K_HDISC, 0);
            end
        end
    end

    initial begin : stimulus
        int n;
        ic_rst_n    = 1'b0;
        transmit_en = 1'b0;
        tx_hrst     = 1'b0;
        tx_mode     = 2'b00;
        tx_paysz    = '0;
        rx_busy     = 1'b0;
        hrst_tx_en  = 1'b0;
        repeat (3) @(posedge ic_clk);
        #2;
        check("reset outputs", 32'(outs), 32'h0);
        @(posedge ic_clk);
        #1;
        ic_rst_n = 1'b1;
        @(negedge ic_clk);
        check("idle outputs", 32'(outs), 32'h0);

        // Normal two-byte message.
        push_normal2();
        @(posedge ic_clk); #1;
        tx_paysz    = 10'd2;
        transmit_en = 1'b1;
        wait_done("normal2");
        transmit_en = 1'b0;
        repeat (2) @(posedge ic_clk);

        // Hard reset from IDLE.
        push_rst_frame();
        @(posedge ic_clk); #1;
        tx_hrst = 1'b1;
        wait_done("hard_reset");
        tx_hrst = 1'b0;
        repeat (2) @(posedge ic_clk);

        // Cable reset.
        push_rst_frame();
        @(posedge ic_clk); #1;
        tx_mode     = 2'b01;
        tx_paysz    = 10'd4;
        transmit_en = 1'b1;
        wait_done("cable_reset");
        transmit_en = 1'b0;
        tx_mode     = 2'b00;
        repeat (2) @(posedge ic_clk);

        // Empty payload: SOP straight to CRC.
        push_ev(K_PRE, 128);
        push_ev(K_SOPC, 0);
        push_ev(K_DATAC, 0);
        push_ev(K_SOP, 20);
        push_ev(K_CRCC, 0);
        push_ev(K_CRC, 40);
        push_ev(K_EOPC, 0);
        push_ev(K_EOP, 5);
        push_ev(K_WAITC, 0);
        push_ev(K_WAIT, 25);
        @(posedge ic_clk); #1;
        tx_paysz    = 10'd0;
        transmit_en = 1'b1;
        wait_done("paysz0");
        transmit_en = 1'b0;
        repeat (2) @(posedge ic_clk);

        // Hard-reset abort three bits into byte 1.
        push_ev(K_PRE, 128);
        push_ev(K_LD, 0);
        push_ev(K_SOPC, 0);
        push_ev(K_SOP, 20);
        push_ev(K_TXDR, 0);
        push_ev(K_LD, 0);
        push_ev(K_TXDR, 0);
        push_ev(K_DATA, 13);
        push_ev(K_EOPC, 0);
        push_ev(K_EOP, 5);
        push_rst_frame();
        @(posedge ic_clk); #1;
        tx_paysz    = 10'd3;
        transmit_en = 1'b1;
        n = 0;
        for (int t = 0; t < BUDGET && n < 13; t++) begin
            @(negedge ic_clk);
            if (data_en && bit_clk_red) n++;
        end
        check("abort reached bit 13", 32'(n), 32'd13);
        @(posedge ic_clk); #1;
        tx_hrst = 1'b1;
        wait_done("abort");
        tx_hrst     = 1'b0;
        transmit_en = 1'b0;
        repeat (2) @(posedge ic_clk);

        // Discards while the receiver is busy.
        push_ev(K_MDISC, 0);
        @(posedge ic_clk); #1;
        rx_busy     = 1'b1;
        transmit_en = 1'b1;
        repeat (4) @(negedge ic_clk);
        check("msg_disc busy", 32'(tx_busy), 32'd0);
        push_ev(K_HDISC, 0);
        @(posedge ic_clk); #1;
        tx_hrst = 1'b1;
        repeat (4) @(negedge ic_clk);
        check("hrst_disc busy", 32'(tx_busy), 32'd0);
        check("disc drained", 32'(exp_q.size()), 32'd0);
        @(posedge ic_clk); #1;
        tx_hrst     = 1'b0;
        transmit_en = 1'b0;
        rx_busy     = 1'b0;
        repeat (2) @(posedge ic_clk);

        // Reset in the middle of CRC, then a full frame.
        push_ev(K_PRE, 128);
        push_ev(K_LD, 0);
        push_ev(K_SOPC, 0);
        push_ev(K_SOP, 20);
        push_ev(K_DATAC, 0);
        push_ev(K_DATA, 10);
        @(posedge ic_clk); #1;
        tx_paysz    = 10'd1;
        transmit_en = 1'b1;
        n = 0;
        while (!crc_en && n < BUDGET) begin
            @(negedge ic_clk);
            n++;
        end
        check("reached crc", 32'(crc_en), 32'd1);
        repeat (3) @(negedge ic_clk);
        check("pre-reset drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge ic_clk); #2;
        ic_rst_n = 1'b0;
        #1;
        check("mid-crc reset outputs", 32'(outs), 32'h0);
        transmit_en = 1'b0;
        repeat (3) @(posedge ic_clk);
        #1;
        ic_rst_n = 1'b1;
        push_normal2();
        @(posedge ic_clk); #1;
        tx_paysz    = 10'd2;
        transmit_en = 1'b1;
        wait_done("after_reset");
        transmit_en = 1'b0;

        repeat (5) @(negedge ic_clk);
        check("final idle outputs", 32'(outs), 32'h0);
        check("queue empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
